// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Brief    : Bit-serial A - B controller driving a one-bit difference/borrow
//            cell LSB first over W cycles, with start/busy/done handshake.
//            Optional macro SERIAL_SUB_SAT_EN: unsigned saturating result.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int            CW     = $clog2(W) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_br;

    logic         w_d1;
    logic         w_b1;
    logic         w_d;
    logic         w_b2;
    logic         w_br_next;
    logic [W-1:0] w_res_next;

    // Two cascaded half-subtractors: operand bits, then the held borrow.
    assign w_d1      = r_a[0] ^ r_b[0];
    assign w_b1      = ~r_a[0] & r_b[0];
    assign w_d       = w_d1 ^ r_br;
    assign w_b2      = ~w_d1 & r_br;
    assign w_br_next = w_b1 | w_b2;

    // The minuend register doubles as the result register: each difference
    // bit enters at the MSB as the consumed minuend bit leaves at the LSB.
    generate
        if (W == 1) begin : g_w1
            assign w_res_next = w_d;
        end else begin : g_wn
            assign w_res_next = {w_d, r_a[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= w_res_next;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bout    <= w_br_next;
`ifdef SERIAL_SUB_SAT_EN
                        diff    <= w_br_next ? '0 : w_res_next;
`else
                        diff    <= w_res_next;
`endif
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Brief    : Self-checking bench for serial_sub_ctrl (W=8): vector table,
//            random operands vs. arithmetic reference, handshake corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    localparam int W = 8;
`ifdef SERIAL_SUB_SAT_EN
    localparam bit C_SAT = 1'b1;
`else
    localparam bit C_SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned arithmetic on the whole operands.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned full;
        full = (int'(a) - int'(b)) & ((1 << W) - 1);
        if (C_SAT && a < b) return '0;
        return full[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b);
        return a < b;
    endfunction

    // Called just after an edge with the DUT idle; checks the full timeline.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_b, input string name);
        logic [W-1:0] prev_d;
        logic         prev_b;
        logic         busy_ok;
        logic         stable;
        prev_d = diff;
        prev_b = bout;
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        busy_ok = 1'b1;
        stable  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
            if (diff !== prev_d || bout !== prev_b) stable = 1'b0;
            tick();
        end
        chk({name, " busy_window"}, 32'(busy_ok), 32'd1);
        chk({name, " out_stable_in_run"}, 32'(stable), 32'd1);
        chk({name, " busy_done_at_end"}, {30'd0, busy, done}, 32'b01);
        chk({name, " diff"}, 32'(diff), 32'(exp_d));
        chk({name, " bout"}, 32'(bout), 32'(exp_b));
        tick();
        chk({name, " done_one_cycle"}, {30'd0, busy, done}, 32'b00);
        chk({name, " diff_held"}, 32'(diff), 32'(exp_d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           ndone;
        logic [W-1:0] cap_d;
        logic         cap_b;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'h5A, b: 8'h23, d: 8'h37, bo: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h20, d: (C_SAT ? 8'h00 : 8'hF0), bo: 1'b1};
        vecs[2] = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h01, d: (C_SAT ? 8'h00 : 8'hFF), bo: 1'b1};
        vecs[5] = '{a: 8'hC3, b: 8'h3C, d: 8'h87, bo: 1'b0};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        tick(); tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("idle no activity", 32'(ndone), 32'd0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) rb = ra + W'($urandom_range(1, 3));
            run_op(ra, rb, ref_diff(ra, rb), ref_bout(ra, rb), $sformatf("rnd%0d", i));
        end

        // Start during RUN must be ignored and not queued.
        a_in = 8'h5A; b_in = 8'h23; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a_in = 8'h01; b_in = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; cap_d = '0; cap_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin ndone++; cap_d = diff; cap_b = bout; end
            tick();
        end
        chk("start_in_run done_count", 32'(ndone), 32'd1);
        chk("start_in_run diff", 32'(cap_d), 32'h37);
        chk("start_in_run bout", 32'(cap_b), 32'd0);

        // Start held high: accepted once per pass through IDLE.
        a_in = 8'h33; b_in = 8'h44; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("held_start done_count", 32'(ndone), 32'd3);
        chk("held_start diff", 32'(diff), 32'(ref_diff(8'h33, 8'h44)));
        chk("held_start bout", 32'(bout), 32'd1);

        // Reset mid-RUN with start asserted alongside: reset wins.
        a_in = 8'h5A; b_in = 8'h23; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("midrun_rst busy", 32'(busy), 32'd0);
        chk("midrun_rst done", 32'(done), 32'd0);
        chk("midrun_rst diff", 32'(diff), 32'd0);
        chk("midrun_rst bout", 32'(bout), 32'd0);
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (busy === 1'b1 || done === 1'b1) ndone++;
        end
        chk("midrun_rst stays_idle", 32'(ndone), 32'd0);
        run_op(8'h09, 8'h04, 8'h05, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
